z3_job_sequencer: RTL and testbench
===================================

// Module: z3_job_sequencer
// PURPOSE
//  Job-level sequencer between the 64b input width converter and the z3 FP encoder DUT.
//  Parses a header beat carrying value count N, then forwards N values to the encoder.
//  Zero-pads the last partial block and discards surplus input beats.
//  Forwards encoder output with tlast suppressed, then closes each job with a status trailer beat + tlast.
// PARAMETERS
//  DATA_W        64      stream/value width (sign,expo,frac packed)
//  BLOCK_VALUES  4       values per encoder block; power of 2
//  CNT_W         32      width of N and of value counters
//  TIMEOUT       65535   max idle cycles in DRAIN before abort
// PORTS
//  clk50mhz_0          in   1       clock
//  peripheral_reset_0  in   1       synchronous reset, active-high
//  s_tdata             in   DATA_W  input stream from width converter
//  s_tvalid/s_tlast    in   1       input valid / end of DMA transfer
//  s_tready            out  1       input ready
//  fp_data             out  DATA_W  value to encoder ({sign,expo,frac})
//  fp_valid            out  1       value valid
//  fp_ready            in   1       encoder accepts value
//  enc_tdata           in   DATA_W  encoded word from encoder
//  enc_tlast/enc_valid in   1       end of encoded block / word valid
//  enc_ready           out  1       sequencer accepts encoded word
//  m_tdata             out  DATA_W  output stream to width converter
//  m_tvalid/m_tlast    out  1       output valid / end of job (trailer only)
//  m_tready            in   1       output ready
// BEHAVIOUR
//  States: HDR, STREAM, PAD, DISCARD, DRAIN, TRAILER. Reset -> HDR, all counters and flags 0.
//   Reset values: s_tready=0, fp_valid=0, m_tvalid=0, m_tlast=0, enc_ready=0.
//  HDR: s_tready=1. On the header handshake:
//   N = s_tdata[CNT_W-1:0]; blocks_exp = ceil(N/BLOCK_VALUES).
//   N==0 -> set ZERO, go TRAILER.
//   Header carries s_tlast with N!=0 -> set SHORT, blocks_exp=0, go DRAIN.
//   Otherwise go STREAM.
//  STREAM: combinational pass-through: fp_data=s_tdata, fp_valid=s_tvalid, s_tready=fp_ready.
//   vals increments on each fp handshake.
//   On the handshake where vals reaches N:
//    vals%BLOCK_VALUES!=0 -> PAD, else DISCARD if !s_tlast, else DRAIN.
//   s_tlast before the Nth value -> set SHORT.
//    blocks_exp = ceil(vals/BLOCK_VALUES) (vals includes the current beat).
//    Go PAD if partial, else DRAIN.
//  PAD: fp_valid=1, fp_data=0, s_tready=0. Pads until vals%BLOCK_VALUES==0. Pads are counted in pad_cnt, not in vals.
//   Next state is DISCARD if the Nth beat had no s_tlast and SHORT is clear, else DRAIN.
//  DISCARD: s_tready=1, fp_valid=0. Each beat is dropped and sets LONG. On s_tlast, go DRAIN.
//  Output path, all states except TRAILER/HDR:
//   m_tdata=enc_tdata, m_tvalid=enc_valid, enc_ready=m_tready, m_tlast=0.
//   out_beats (24b, saturating) increments per m handshake; blocks_done increments per enc_tlast handshake.
//  DRAIN: leave when blocks_done==blocks_exp (checked every cycle, including on entry) -> TRAILER.
//   Idle counter resets on each enc handshake. At TIMEOUT idle cycles, set TIMEOUT flag and go TRAILER.
//  TRAILER: enc_ready=0, s_tready=0, fp_valid=0, m_tvalid=1, m_tlast=1.
//   m_tdata = {4'hE, flags{TIMEOUT,LONG,SHORT,ZERO}, out_beats[23:0], vals[31:0]}.
//   Held stable until m_tready, then clear counters/flags and go HDR.
//  Encoded words arriving in HDR are not accepted (enc_ready=0).
//  Reset mid-job aborts immediately. No trailer is emitted; the encoder is reset by the same signal.
//  Counter widths: vals/N are CNT_W wide. blocks counters are CNT_W-log2(BLOCK_VALUES)+1 wide. No wrap.
// TESTING
//  T1 N=8, 8 beats, last carries tlast; encoder 2 blocks of 3 words ->
//     8 fp beats, 6 m beats with tlast=0, trailer 0xE0_000006_00000008 with tlast.
//  T2 N=5, tlast on 5th beat -> 3 zero pad beats on fp.
//     Trailer waits for the 2nd enc_tlast; flags=0, vals=5.
//  T3 N=0, header with tlast -> no fp beats, trailer flags=0001 issued without encoder activity.
//  T4 N=12, tlast on 6th value -> 2 pads, blocks_exp=2, trailer flags=0010, vals=6.
//  T5 N=4, 6 value beats, tlast on 6th -> 4 fp beats, 2 beats discarded, trailer flags=0100.
//  T6 N=4, encoder never asserts enc_valid -> trailer after TIMEOUT idle cycles, flags=1000.
//     Then random m_tready backpressure on T1: no beat lost/duplicated; trailer held until accepted.

Source files
------------

// File: rtl/z3_job_sequencer.sv
// z3_job_sequencer: header-driven job framing between the 64b width converter and the z3 FP encoder
//
// Sits between the input width converter and the z3 FP encoder. A header beat
// carries the value count N. The next N values go to the encoder, and the last
// partial block is zero-padded. Input beats beyond N are dropped. Encoder output
// is forwarded with tlast held low. Each job then ends with one status trailer
// beat that carries tlast.
//
// Ports
//   clk50mhz_0          in   clock
//   peripheral_reset_0  in   synchronous active-high reset (aborts any job)
//   s_tdata/s_tvalid/s_tlast/s_tready   input stream from width converter
//   fp_data/fp_valid/fp_ready           value stream to encoder
//   enc_tdata/enc_tlast/enc_valid/enc_ready  encoded words from encoder
//   m_tdata/m_tvalid/m_tlast/m_tready   output stream to width converter
module z3_job_sequencer #(
    parameter int DATA_W       = 64,
    parameter int BLOCK_VALUES = 4,
    parameter int CNT_W        = 32,
    parameter int TIMEOUT      = 65535
) (
    input  logic              clk50mhz_0,
    input  logic              peripheral_reset_0,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic [DATA_W-1:0] fp_data,
    output logic              fp_valid,
    input  logic              fp_ready,
    input  logic [DATA_W-1:0] enc_tdata,
    input  logic              enc_tlast,
    input  logic              enc_valid,
    output logic              enc_ready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    output logic              m_tlast,
    input  logic              m_tready
);
    localparam int LOG2_BV = $clog2(BLOCK_VALUES);
    localparam int BLK_W   = CNT_W - LOG2_BV + 1;
    localparam int IDLE_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] HDR     = 3'd0;
    localparam logic [2:0] STREAM  = 3'd1;
    localparam logic [2:0] PAD     = 3'd2;
    localparam logic [2:0] DISCARD = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;
    localparam logic [2:0] TRAILER = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d;
    logic [CNT_W-1:0]   vals_q, vals_d;
    logic [LOG2_BV-1:0] pad_cnt_q, pad_cnt_d;
    logic [BLK_W-1:0]   blocks_exp_q, blocks_exp_d;
    logic [BLK_W-1:0]   blocks_done_q, blocks_done_d;
    logic [23:0]        out_beats_q, out_beats_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic               zero_q, zero_d;
    logic               short_q, short_d;
    logic               long_q, long_d;
    logic               tmo_q, tmo_d;
    logic               nth_last_q, nth_last_d;

    logic [CNT_W-1:0]   vals_inc;
    logic               partial;
    logic [LOG2_BV-1:0] pad_pos;
    logic               out_path;
    logic               enc_hs;

    // Number of encoder blocks needed to hold v values.
    function automatic logic [BLK_W-1:0] ceil_blocks(input logic [CNT_W-1:0] v);
        logic [CNT_W:0] s;
        s = {1'b0, v} + (CNT_W+1)'(BLOCK_VALUES - 1);
        return BLK_W'(s >> LOG2_BV);
    endfunction

    always_comb begin
        state_d       = state_q;
        n_d           = n_q;
        vals_d        = vals_q;
        pad_cnt_d     = pad_cnt_q;
        blocks_exp_d  = blocks_exp_q;
        blocks_done_d = blocks_done_q;
        out_beats_d   = out_beats_q;
        idle_d        = idle_q;
        zero_d        = zero_q;
        short_d       = short_q;
        long_d        = long_q;
        tmo_d         = tmo_q;
        nth_last_d    = nth_last_q;
        s_tready      = 1'b0;
        fp_valid      = 1'b0;
        fp_data       = '0;
        vals_inc      = vals_q + 1'b1;
        partial       = vals_inc[LOG2_BV-1:0] != '0;
        pad_pos       = '0;
        // Encoder output flows through in every state that belongs to an open job.
        out_path      = state_q != HDR && state_q != TRAILER;
        enc_ready     = out_path & m_tready;
        m_tvalid      = out_path & enc_valid;
        m_tlast       = 1'b0;
        m_tdata       = enc_tdata;
        enc_hs        = out_path & enc_valid & m_tready;
        if (enc_hs) begin
            out_beats_d = &out_beats_q ? out_beats_q : out_beats_q + 1'b1;
            blocks_done_d = enc_tlast ? blocks_done_q + 1'b1 : blocks_done_q;
        end
        case (state_q)
            HDR: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    n_d = s_tdata[CNT_W-1:0];
                    if (s_tdata[CNT_W-1:0] == '0) begin
                        zero_d  = 1'b1;
                        state_d = TRAILER;
                    end else if (s_tlast) begin
                        short_d      = 1'b1;
                        blocks_exp_d = '0;
                        state_d      = DRAIN;
                    end else begin
                        blocks_exp_d = ceil_blocks(s_tdata[CNT_W-1:0]);
                        state_d      = STREAM;
                    end
                end
            end
            STREAM: begin
                fp_data  = s_tdata;
                fp_valid = s_tvalid;
                s_tready = fp_ready;
                if (s_tvalid && fp_ready) begin
                    vals_d = vals_inc;
                    if (vals_inc == n_q) begin
                        nth_last_d = s_tlast;
                        state_d    = partial ? PAD : (s_tlast ? DRAIN : DISCARD);
                    end else if (s_tlast) begin
                        // Transfer ended early: only the blocks actually started are expected back.
                        short_d      = 1'b1;
                        blocks_exp_d = ceil_blocks(vals_inc);
                        state_d      = partial ? PAD : DRAIN;
                    end
                end
            end
            PAD: begin
                fp_valid = 1'b1;
                if (fp_ready) begin
                    pad_cnt_d = pad_cnt_q + 1'b1;
                    // Position in the block after this pad, wrapping at BLOCK_VALUES.
                    pad_pos   = vals_q[LOG2_BV-1:0] + pad_cnt_d;
                    if (pad_pos == '0)
                        state_d = (nth_last_q || short_q) ? DRAIN : DISCARD;
                end
            end
            DISCARD: begin
                s_tready = 1'b1;
                if (s_tvalid) begin
                    long_d  = 1'b1;
                    state_d = s_tlast ? DRAIN : DISCARD;
                end
            end
            DRAIN: begin
                if (blocks_done_q == blocks_exp_q) begin
                    state_d = TRAILER;
                end else if (enc_hs) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = TRAILER;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
            end
            TRAILER: begin
                m_tvalid = 1'b1;
                m_tlast  = 1'b1;
                m_tdata  = DATA_W'({4'hE, tmo_q, long_q, short_q, zero_q, out_beats_q, 32'(vals_q)});
                if (m_tready) begin
                    state_d       = HDR;
                    n_d           = '0;
                    vals_d        = '0;
                    pad_cnt_d     = '0;
                    blocks_exp_d  = '0;
                    blocks_done_d = '0;
                    out_beats_d   = '0;
                    idle_d        = '0;
                    zero_d        = 1'b0;
                    short_d       = 1'b0;
                    long_d        = 1'b0;
                    tmo_d         = 1'b0;
                    nth_last_d    = 1'b0;
                end
            end
            default: state_d = HDR;
        endcase
        // Handshake outputs stay low while reset is held, even though the state is already HDR.
        if (peripheral_reset_0) begin
            s_tready  = 1'b0;
            fp_valid  = 1'b0;
            enc_ready = 1'b0;
            m_tvalid  = 1'b0;
            m_tlast   = 1'b0;
        end
    end

    always_ff @(posedge clk50mhz_0) begin
        if (peripheral_reset_0) begin
            state_q       <= HDR;
            n_q           <= '0;
            vals_q        <= '0;
            pad_cnt_q     <= '0;
            blocks_exp_q  <= '0;
            blocks_done_q <= '0;
            out_beats_q   <= '0;
            idle_q        <= '0;
            zero_q        <= 1'b0;
            short_q       <= 1'b0;
            long_q        <= 1'b0;
            tmo_q         <= 1'b0;
            nth_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            n_q           <= n_d;
            vals_q        <= vals_d;
            pad_cnt_q     <= pad_cnt_d;
            blocks_exp_q  <= blocks_exp_d;
            blocks_done_q <= blocks_done_d;
            out_beats_q   <= out_beats_d;
            idle_q        <= idle_d;
            zero_q        <= zero_d;
            short_q       <= short_d;
            long_q        <= long_d;
            tmo_q         <= tmo_d;
            nth_last_q    <= nth_last_d;
        end
    end
endmodule

// File: tb/tb_z3_job_sequencer.sv
// tb_z3_job_sequencer: scoreboard bench with directed jobs and a 3-word-per-block encoder model
module tb_z3_job_sequencer;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata;
    logic        s_tvalid, s_tlast, s_tready;
    logic [63:0] fp_data;
    logic        fp_valid, fp_ready;
    logic [63:0] enc_tdata;
    logic        enc_tlast, enc_valid, enc_ready;
    logic [63:0] m_tdata;
    logic        m_tvalid, m_tlast, m_tready;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          fp_seen = 0;
    int          fed = 0;
    int          emitted = 0;
    bit          enc_en = 1'b1;
    bit          bp = 1'b0;
    bit          enc_hs_n = 1'b0;
    logic [63:0] exp_fp[$];
    logic [63:0] exp_m[$];
    logic [63:0] exp_tr[$];

    always #5 clk = ~clk;

    z3_job_sequencer #(.DATA_W(64), .BLOCK_VALUES(4), .CNT_W(32), .TIMEOUT(TMO)) dut (
        .clk50mhz_0(clk), .peripheral_reset_0(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .fp_data(fp_data), .fp_valid(fp_valid), .fp_ready(fp_ready),
        .enc_tdata(enc_tdata), .enc_tlast(enc_tlast), .enc_valid(enc_valid), .enc_ready(enc_ready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic miss(input string name, input logic [63:0] act);
        checks++;
        fails++;
        $display("FAIL %s: got beat %h expected none", name, act);
    endtask

    // Monitor: samples handshakes mid-cycle and pops the scoreboards.
    always @(negedge clk) begin
        cyc++;
        enc_hs_n = enc_valid && enc_ready;
        if (!rst) begin
            if (fp_valid && fp_ready) begin
                if (exp_fp.size() == 0) miss("fp_unexpected", fp_data);
                else chk("fp_data", fp_data, exp_fp.pop_front());
                fp_seen++;
                if (fp_seen % 4 == 0 && enc_en) fed++;
            end
            if (m_tvalid && m_tlast) begin
                if (exp_tr.size() == 0) miss("trailer_unexpected", m_tdata);
                else if (m_tready) begin
                    chk("m_pending_at_trailer", 64'(exp_m.size()), 64'd0);
                    chk("trailer", m_tdata, exp_tr.pop_front());
                end else chk("trailer_hold", m_tdata, exp_tr[0]);
            end else if (m_tvalid && m_tready) begin
                if (exp_m.size() == 0) miss("m_unexpected", m_tdata);
                else chk("m_data", m_tdata, exp_m.pop_front());
            end
        end
    end

    // Encoder model: one 3-word block per 4 values consumed; pushes each word as it is offered.
    initial begin
        int w = 0;
        int seq = 0;
        enc_valid = 1'b0;
        enc_tlast = 1'b0;
        enc_tdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (enc_valid && enc_hs_n) enc_valid = 1'b0;
            if (!enc_valid && emitted < fed) begin
                seq++;
                enc_tdata = {32'hC0DE0000, 32'(seq)};
                enc_tlast = (w == 2);
                enc_valid = 1'b1;
                exp_m.push_back(enc_tdata);
                if (w == 2) begin
                    w = 0;
                    emitted++;
                end else w++;
            end
        end
    end

    initial begin
        m_tready = 1'b1;
        fp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            fp_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic send(input logic [63:0] d, input logic l);
        int n = 0;
        s_tdata = d;
        s_tlast = l;
        s_tvalid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!(s_tvalid && s_tready) && n < 500);
        if (n >= 500) begin
            checks++;
            fails++;
            $display("FAIL s_handshake_timeout: got no s_tready after %0d cycles, required handshake", n);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic job(input int id, input logic [31:0] n, input bit hdr_last, input int beats,
                       input int fwd, input int pads, input logic [63:0] trailer, input int min_wait);
        int t0;
        int k = 0;
        for (int i = 0; i < fwd; i++) exp_fp.push_back({24'hDA7A00, 8'(id), 32'(i)});
        for (int i = 0; i < pads; i++) exp_fp.push_back(64'd0);
        exp_tr.push_back(trailer);
        send({32'd0, n}, hdr_last);
        for (int i = 0; i < beats; i++) send({24'hDA7A00, 8'(id), 32'(i)}, i == beats - 1);
        t0 = cyc;
        while (exp_tr.size() != 0 && k < TMO + 2000) begin
            @(negedge clk);
            k++;
        end
        if (exp_tr.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL trailer_timeout job %0d: got no trailer, required %h", id, trailer);
            exp_tr.delete();
        end
        if (min_wait > 0) chk("timeout_wait", 64'((cyc - t0) >= min_wait), 64'd1);
        chk("fp_left", 64'(exp_fp.size()), 64'd0);
        exp_fp.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_tready", 64'(s_tready), 64'd0);
        chk("rst_fp_valid", 64'(fp_valid), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tlast", 64'(m_tlast), 64'd0);
        chk("rst_enc_ready", 64'(enc_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("hdr_s_tready", 64'(s_tready), 64'd1);
        chk("hdr_enc_ready", 64'(enc_ready), 64'd0);
        @(posedge clk);
        #1;
        job(1, 32'd8, 1'b0, 8, 8, 0, 64'hE000000600000008, 0);
        job(2, 32'd5, 1'b0, 5, 5, 3, 64'hE000000600000005, 0);
        job(3, 32'd0, 1'b1, 0, 0, 0, 64'hE100000000000000, 0);
        job(4, 32'd12, 1'b0, 6, 6, 2, 64'hE200000600000006, 0);
        job(5, 32'd4, 1'b0, 6, 4, 0, 64'hE400000300000004, 0);
        enc_en = 1'b0;
        job(6, 32'd4, 1'b0, 4, 4, 0, 64'hE800000000000004, TMO);
        enc_en = 1'b1;
        bp = 1'b1;
        job(7, 32'd8, 1'b0, 8, 8, 0, 64'hE000000600000008, 0);
        bp = 1'b0;
        repeat (5) @(posedge clk);
        chk("m_left", 64'(exp_m.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
